// File: rtl/comparator_pkg.sv
// Shared types and encodings for the registered magnitude comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// cmp_result_t is the one-hot relation vector {gt, eq, lt}. CMP_RESET is the
// all-zero value held before any operand pair has been captured.
package comparator_pkg;

    typedef logic [2:0] cmp_result_t;

    localparam cmp_result_t CMP_GT    = 3'b100;
    localparam cmp_result_t CMP_EQ    = 3'b010;
    localparam cmp_result_t CMP_LT    = 3'b001;
    localparam cmp_result_t CMP_RESET = 3'b000;

    // Pack individual relation flags into the result encoding.
    function automatic cmp_result_t pack_flags(input logic gt, input logic eq, input logic lt);
        return {gt, eq, lt};
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One bit position of an MSB-first magnitude compare chain.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   a_i, b_i              operand bits at this position
//   gt_in, eq_in, lt_in   relation decided by the more-significant bits
//   gt_o,  eq_o,  lt_o    relation after including this bit
// SWAP exchanges the gt/lt decision; used only at the MSB of a signed compare,
// where a set bit means "negative" and therefore the smaller operand.
module cmp_bit_cell #(
    parameter bit SWAP = 1'b0
) (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_in,
    input  logic eq_in,
    input  logic lt_in,
    output logic gt_o,
    output logic eq_o,
    output logic lt_o
);

    logic a_hi;
    logic b_hi;

    assign a_hi = a_i & ~b_i;
    assign b_hi = ~a_i & b_i;

    always_comb begin
        gt_o = gt_in;
        eq_o = eq_in;
        lt_o = lt_in;
        // Only the first differing bit from the top may decide; once a higher
        // bit has settled the relation, it passes through unchanged.
        if (eq_in) begin
            gt_o = SWAP ? b_hi : a_hi;
            lt_o = SWAP ? a_hi : b_hi;
            eq_o = ~(a_i ^ b_i);
        end
    end

endmodule

// File: rtl/comparator_2bit.sv
// Registered magnitude comparator, one-hot {gt,eq,lt} result.
// Latency: 1 cycle from the capturing clk edge; one compare per cycle.
// Backpressure: none; c and out_valid hold while in_valid is low.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_valid     capture a/b on this edge
//   a, b         operands (unsigned, or two's complement when SIGNED=1)
//   c            registered relation: 100 a>b, 010 a==b, 001 a<b, 000 after reset
//   out_valid    set by the first capture, cleared only by reset
module comparator_2bit
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH  = 2,
    parameter int          SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_t      c,
    output logic             out_valid
);

    // Chain runs from the MSB cell (seeded with "equal so far") down to bit 0.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        localparam bit SWAP = (SIGNED != 0) && (i == int'(WIDTH) - 1);

        logic gt_in;
        logic eq_in;
        logic lt_in;
        logic gt_o;
        logic eq_o;
        logic lt_o;

        if (i == int'(WIDTH) - 1) begin : g_seed
            assign gt_in = 1'b0;
            assign eq_in = 1'b1;
            assign lt_in = 1'b0;
        end else begin : g_link
            assign gt_in = g_cell[i+1].gt_o;
            assign eq_in = g_cell[i+1].eq_o;
            assign lt_in = g_cell[i+1].lt_o;
        end

        cmp_bit_cell #(
            .SWAP (SWAP)
        ) u_cell (
            .a_i   (a[i]),
            .b_i   (b[i]),
            .gt_in (gt_in),
            .eq_in (eq_in),
            .lt_in (lt_in),
            .gt_o  (gt_o),
            .eq_o  (eq_o),
            .lt_o  (lt_o)
        );
    end

    cmp_result_t c_nxt;

    assign c_nxt = pack_flags(g_cell[0].gt_o, g_cell[0].eq_o, g_cell[0].lt_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= CMP_RESET;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            c         <= c_nxt;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_comparator_2bit.sv
// Self-checking bench for comparator_2bit: 2-bit unsigned/signed and 32-bit
// unsigned/signed instances, queue scoreboard against an integer reference.
module tb_comparator_2bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic [1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [31:0] a2 = '0, b2 = '0, a3 = '0, b3 = '0;
    logic [2:0]  c0, c1, c2, c3;
    logic        ov0, ov1, ov2, ov3;

    logic [2:0]  q0[$], q1[$], q2[$], q3[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comparator_2bit #(.WIDTH(2),  .SIGNED(0)) u_u2  (.clk(clk), .rst_n(rst_n), .in_valid(v0), .a(a0), .b(b0), .c(c0), .out_valid(ov0));
    comparator_2bit #(.WIDTH(2),  .SIGNED(1)) u_s2  (.clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c(c1), .out_valid(ov1));
    comparator_2bit #(.WIDTH(32), .SIGNED(0)) u_u32 (.clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2), .c(c2), .out_valid(ov2));
    comparator_2bit #(.WIDTH(32), .SIGNED(1)) u_s32 (.clk(clk), .rst_n(rst_n), .in_valid(v3), .a(a3), .b(b3), .c(c3), .out_valid(ov3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Integer reference: operands widened to 64-bit signed values.
    function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y,
                                           input int w, input bit sgn);
        longint sx;
        longint sy;
        sx = longint'({32'b0, x});
        sy = longint'({32'b0, y});
        if (sgn && x[w-1]) sx = sx - (longint'(1) << w);
        if (sgn && y[w-1]) sy = sy - (longint'(1) << w);
        if (sx > sy)       return 3'b100;
        else if (sx == sy) return 3'b010;
        else               return 3'b001;
    endfunction

    // Push expectations for every instance with valid set, advance one clock,
    // then compare each produced result at the following falling edge.
    task automatic cycle();
        logic [2:0] e;
        if (v0) q0.push_back(ref_cmp({30'b0, a0}, {30'b0, b0}, 2, 1'b0));
        if (v1) q1.push_back(ref_cmp({30'b0, a1}, {30'b0, b1}, 2, 1'b1));
        if (v2) q2.push_back(ref_cmp(a2, b2, 32, 1'b0));
        if (v3) q3.push_back(ref_cmp(a3, b3, 32, 1'b1));
        @(posedge clk);
        @(negedge clk);
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("u2_c", c0, e); check("u2_ov", ov0, 1); check("u2_onehot", $onehot(c0), 1);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("s2_c", c1, e); check("s2_ov", ov1, 1); check("s2_onehot", $onehot(c1), 1);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("u32_c", c2, e); check("u32_ov", ov2, 1); check("u32_onehot", $onehot(c2), 1);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            check("s32_c", c3, e); check("s32_ov", ov3, 1); check("s32_onehot", $onehot(c3), 1);
        end
    endtask

    task automatic idle_all();
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_c0", c0, 3'b000);  check("rst_ov0", ov0, 0);
        check("rst_c1", c1, 3'b000);  check("rst_ov1", ov1, 0);
        check("rst_c2", c2, 3'b000);  check("rst_ov2", ov2, 0);
        check("rst_c3", c3, 3'b000);  check("rst_ov3", ov3, 0);
        rst_n = 1'b1;

        // Exhaustive 2-bit sweep, a major / b minor, on both unsigned and signed
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a0 = 2'(i); b0 = 2'(j); v0 = 1'b1;
                a1 = 2'(i); b1 = 2'(j); v1 = 1'b1;
                cycle();
            end
        end
        idle_all();

        // Explicit examples
        a0 = 2'd0; b0 = 2'd1; v0 = 1'b1; cycle(); check("ex_0_1", c0, 3'b001);
        a0 = 2'd2; b0 = 2'd1;            cycle(); check("ex_2_1", c0, 3'b100);
        a0 = 2'd3; b0 = 2'd3;            cycle(); check("ex_3_3", c0, 3'b010);
        idle_all();

        // Signed examples
        a1 = 2'b10; b1 = 2'b01; v1 = 1'b1; cycle(); check("sgn_m2_p1", c1, 3'b001);
        a1 = 2'b11; b1 = 2'b10;            cycle(); check("sgn_m1_m2", c1, 3'b100);
        idle_all();

        // Wide operands
        a2 = 32'h8000_0000; b2 = 32'h7FFF_FFFF; v2 = 1'b1;
        a3 = 32'h8000_0000; b3 = 32'h7FFF_FFFF; v3 = 1'b1;
        cycle();
        check("wide_u", c2, 3'b100);
        check("wide_s", c3, 3'b001);
        a2 = 32'hFFFF_FFFF; b2 = 32'hFFFF_FFFF; a3 = 32'hFFFF_FFFF; b3 = 32'h0000_0000;
        cycle();
        check("wide_u_eq", c2, 3'b010);
        check("wide_s_neg1", c3, 3'b001);
        idle_all();

        // Hold: capture 2 vs 3, then change operands with valid low
        a0 = 2'd2; b0 = 2'd3; v0 = 1'b1; cycle();
        v0 = 1'b0; a0 = 2'd3; b0 = 2'd0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("hold_c", c0, 3'b001);
            check("hold_ov", ov0, 1);
        end

        // Reset mid-operation with a pending capture
        a0 = 2'd3; b0 = 2'd0; v0 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_c", c0, 3'b000);
        check("async_rst_ov", ov0, 0);
        @(posedge clk); #1;
        check("rst_hold_c", c0, 3'b000);
        check("rst_hold_ov", ov0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a0 = 2'd1; b0 = 2'd1; v0 = 1'b1;
        cycle();
        check("post_rst_c", c0, 3'b010);
        idle_all();

        // Random back-to-back traffic on all instances
        for (int n = 0; n < 1000; n++) begin
            a0 = 2'($urandom); b0 = 2'($urandom); v0 = 1'b1;
            a1 = 2'($urandom); b1 = 2'($urandom); v1 = 1'b1;
            a2 = $urandom; b2 = ($urandom_range(0, 3) == 0) ? a2 : $urandom; v2 = 1'b1;
            a3 = $urandom; b3 = ($urandom_range(0, 3) == 0) ? a3 : $urandom; v3 = 1'b1;
            cycle();
        end
        idle_all();

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        check("q3_drained", q3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
